seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Iterative shift-add multiplier for the Lab CPU datapath; takes one multiplier bit per cycle.
- Sits directly upstream of the write-back 2-to-1 select: product_o[size-1:0] drives the select's data1_i, and the ALU result drives data0_i.
- busy_o is used by the control unit to stall the PC while a multiply is in flight.

Parameters:
- size, 32, operand width in bits; product width is 2*size.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  request a multiply; sampled only in IDLE or DONE.
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
- src1_i  input  size  multiplicand.
- src2_i  input  size  multiplier.
- busy_o  output  1  high while in BUSY.
- done_o  output  1  one-cycle pulse: product_o is newly valid.
- product_o  output  2*size  product; held stable until the next accepted start.

Behaviour:
- Reset: on a rising edge with rst_i=1, state=IDLE and busy_o=0, done_o=0, product_o=0. All internal registers are cleared. This takes priority over everything else, including mid-BUSY, where the operation is aborted and no done_o is produced.
- Internal registers:
  - mcand, 2*size bits.
  - mplier, size bits.
  - acc, 2*size bits.
  - neg, 1 bit.
  - cnt, counter 0..size.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - busy_o=0, done_o=0.
  - start_i=1 -> BUSY. On that edge:
    - mcand <= zero-extended |src1_i|.
    - mplier <= |src2_i|.
    - acc <= 0, cnt <= 0.
    - neg <= signed_i & (src1_i[size-1] ^ src2_i[size-1]).
  - |x| is the two's-complement magnitude when signed_i=1; otherwise x unchanged. Magnitude is taken as an unsigned size-bit value, so the most negative input becomes 2^(size-1), which is legal.
- BUSY:
  - busy_o=1.
  - Each edge:
    - if mplier[0], acc <= acc + mcand (mod 2^(2*size)).
    - mcand <= mcand << 1.
    - mplier <= mplier >> 1.
    - cnt <= cnt + 1.
  - When cnt reaches size-1 on this edge (i.e. the size-th iteration), -> DONE. On the same edge, product_o <= neg ? -(final acc) : final acc, where final acc includes the current iteration's add.
  - start_i is ignored in BUSY.
- DONE:
  - done_o=1, busy_o=0, for exactly one cycle.
  - start_i=1 -> BUSY, with operands latched as in IDLE (back-to-back). Otherwise -> IDLE.
- Latency: start_i sampled at edge E gives done_o high in the cycle following edge E+size. busy_o is high for exactly size cycles.
- product_o changes only on the DONE-entry edge or on reset. It is not cleared by a new start.
- Boundaries:
  - Zero operand: still takes size cycles (without the optional feature); product 0.
  - Signed (-2^(size-1)) * (-2^(size-1)) = 2^(2*size-2), positive, no overflow.
  - Unsigned all-ones * all-ones = 2^(2*size) - 2^(size+1) + 1.
  - start_i held high continuously: a new operation launches from each DONE cycle.

Optional Feature:
- Macro: SEQ_MULTIPLIER_EARLY_TERM_EN.
- Defined: in BUSY, the transition to DONE also occurs on any edge where the next mplier value (after the shift) is zero. BUSY length = max(1, bit-length of |src2_i|). Examples:
  - src2=0 or 1: 1 cycle.
  - src2=5: 3 cycles.
  - src2 = 2^(size-1) unsigned: size cycles.
- Result is identical to the non-terminating case.
- Not defined: fixed size-cycle BUSY as above.

Test Plan:
- Reset mid-operation: start 7*9 unsigned, assert rst_i on the 3rd BUSY cycle -> next cycle busy_o=0, done_o=0, product_o=0, no done_o pulse afterwards.
- Unsigned basic: src1=7, src2=9, signed_i=0, start at edge E -> busy_o high 32 cycles, done_o pulse after edge E+32, product_o=63.
- Signed mix: src1=-3 (0xFFFFFFFD), src2=5, signed_i=1 -> product_o=0xFFFFFFFF_FFFFFFF1 (-15). Same operands with signed_i=0 -> 0x00000004_FFFFFFF1.
- Extremes:
  - 0x80000000 * 0x80000000 signed -> 0x40000000_00000000.
  - 0xFFFFFFFF * 0xFFFFFFFF unsigned -> 0xFFFFFFFE_00000001.
- Handshake: start_i pulsed during BUSY -> ignored. start_i held high across DONE with new operands 2*3 -> second done_o exactly 33 cycles after the first, product_o=6, first product held until then.
- With SEQ_MULTIPLIER_EARLY_TERM_EN: 100*5 -> busy_o 3 cycles, product_o=500. 100*0 -> busy_o 1 cycle, product_o=0.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled by magnitude/negate.
// Optional SEQ_MULTIPLIER_EARLY_TERM_EN ends BUSY once the remaining multiplier bits are all zero.
module seq_multiplier #(
  parameter int size = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [size-1:0]   src1_i,
  input  logic [size-1:0]   src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*size-1:0] product_o
);

  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [2*size-1:0] mcand_q, mcand_d;
  logic [2*size-1:0] acc_q, acc_d;
  logic [2*size-1:0] product_q, product_d;
  logic [size-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [size-1:0]   mag1, mag2;
  logic [2*size-1:0] acc_sum;
  logic              last;

  always_comb begin
    // Magnitudes are unsigned size-bit values, so the most negative input maps to 2^(size-1).
    mag1    = (signed_i && src1_i[size-1]) ? -src1_i : src1_i;
    mag2    = (signed_i && src2_i[size-1]) ? -src2_i : src2_i;
    acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    last    = (cnt_q == CW'(size - 1)) || ((mplier_q >> 1) == '0);
`else
    last    = (cnt_q == CW'(size - 1));
`endif

    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = BUSY;
          mcand_d  = {{size{1'b0}}, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = signed_i & (src1_i[size-1] ^ src2_i[size-1]);
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        busy_d   = 1'b1;
        if (last) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = neg_q ? -acc_sum : acc_sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: products, BUSY length, done pulse, reset abort, start handshake.
// Define SEQ_MULTIPLIER_EARLY_TERM_EN for both bench and RTL to exercise early termination.
module tb_seq_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] product_o;

  int checks   = 0;
  int failures = 0;

  seq_multiplier #(.size(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .product_o (product_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected number of BUSY cycles for a given multiplier operand.
  function automatic int exp_busy(input logic [31:0] b, input logic s);
    logic [31:0] mag;
    int len;
    mag = (s && b[31]) ? -b : b;
    len = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    return len;
`else
    return 32;
`endif
  endfunction

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] exp);
    int n;
    @(negedge clk_i);
    src1_i = a; src2_i = b; signed_i = s; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      @(posedge clk_i); #1;
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy(b, s)));
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_product"}, product_o, exp);
    @(posedge clk_i); #1;
    check({tag, "_done_drop"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int n;
    int pulses;
    int held_bad;

    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; src1_i = '0; src2_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_product", product_o, 64'd0);

    run_mul("u_7x9", 32'd7, 32'd9, 1'b0, 64'd63);

    // Reset asserted during the 3rd BUSY cycle aborts the operation.
    @(negedge clk_i);
    src1_i = 32'd7; src2_i = 32'd9; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    check("rst_mid_product", product_o, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) pulses++;
    end
    check("rst_mid_no_done", 64'(pulses), 64'd0);

    run_mul("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run_mul("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
    run_mul("s_7xm9", 32'd7, 32'hFFFF_FFF7, 1'b1, 64'hFFFF_FFFF_FFFF_FFC1);
    run_mul("s_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
    run_mul("s_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_mul("u_max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_mul("u_0xmax", 32'd0, 32'hFFFF_FFFF, 1'b0, 64'd0);
    run_mul("u_100x5", 32'd100, 32'd5, 1'b0, 64'd500);
    run_mul("u_100x0", 32'd100, 32'd0, 1'b0, 64'd0);

    // start_i pulsed while BUSY must not disturb the running multiply.
    @(negedge clk_i);
    src1_i = 32'd7; src2_i = 32'd9; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (busy_o && n < 200) begin
      n++;
      if (n == 2) begin start_i = 1'b1; src1_i = 32'd1; src2_i = 32'd1; end
      if (n == 3) start_i = 1'b0;
      @(posedge clk_i); #1;
    end
    start_i = 1'b0;
    check("ign_busy_cycles", 64'(n), 64'(exp_busy(32'd9, 1'b0)));
    check("ign_done", 64'(done_o), 64'd1);
    check("ign_product", product_o, 64'd63);
    repeat (3) @(posedge clk_i);
    #1 check("ign_idle_busy", 64'(busy_o), 64'd0);

    // start_i held across DONE launches a back-to-back multiply.
    @(negedge clk_i);
    src1_i = 32'd7; src2_i = 32'd9; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    src1_i = 32'd2; src2_i = 32'd3;
    n = 0;
    while (!done_o && n < 200) begin
      n++;
      @(posedge clk_i); #1;
    end
    check("b2b_first_done", 64'(done_o), 64'd1);
    check("b2b_first_product", product_o, 64'd63);
    n = 0;
    held_bad = 0;
    while (n < 200) begin
      @(posedge clk_i); #1;
      n++;
      if (n == 1) start_i = 1'b0;
      if (done_o) break;
      if (product_o !== 64'd63) held_bad = 1;
    end
    check("b2b_gap", 64'(n), 64'(exp_busy(32'd3, 1'b0) + 1));
    check("b2b_first_held", 64'(held_bad), 64'd0);
    check("b2b_second_product", product_o, 64'd6);
    @(posedge clk_i); #1;
    check("b2b_no_third", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
